// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receive stage.
// The rx line passes through a two-flop synchroniser; a five-state FSM
// detects the start bit, samples every bit at its mid-point and checks
// the stop bit. A good byte is presented with a one-cycle o_valid pulse,
// a low stop bit with a one-cycle o_framing_error pulse.
module uart_receiver #(
    parameter int BAUD_RATE       = 10000,
    parameter int CLOCK_FREQUENCY = 250000
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_framing_error,
    output logic       o_busy
);

    localparam int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2;

    // Counter values at which a bit period ends / the start bit is checked.
    localparam logic [15:0] BIT_END  = 16'(CYCLES_PER_SAMPLE - 1);
    localparam logic [15:0] HALF_END = 16'(HALF_SAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] counter_q, counter_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        busy_q;
    logic        sync1_q, sync2_q;
    logic        rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser on the asynchronous rx line; idles high.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            counter_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    // Next-state logic for the FSM, cycle counter, bit index and shift register.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    counter_d = 16'd0;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (counter_q == HALF_END) begin
                    counter_d = 16'd0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: glitch, not a start bit.
                        state_d   = IDLE;
                    end
                end else begin
                    counter_d = counter_q + 16'd1;
                end
            end
            DATA: begin
                if (counter_q == BIT_END) begin
                    shift_d[bit_idx_q] = rx_s;
                    counter_d          = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    counter_d = counter_q + 16'd1;
                end
            end
            STOP: begin
                if (counter_q == BIT_END) begin
                    counter_d = 16'd0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    counter_d = counter_q + 16'd1;
                end
            end
            WAIT_IDLE: begin
                // Wait out a held-low line so a break yields a single error.
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = 16'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Output decode: the stop-bit decision produces either o_valid or o_framing_error.
    always_comb begin
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        data_d  = data_q;
        case (state_q)
            STOP: begin
                if (counter_q == BIT_END) begin
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign o_data          = data_q;
    assign o_valid         = valid_q;
    assign o_framing_error = ferr_q;
    assign o_busy          = busy_q;

endmodule
